// File: rtl/fft_bitrev_frame_buffer.sv
// Ping-pong frame buffer ahead of the FFT input-prep stage: samples stream in
// one per cycle and land at their bit-reversed address, frames leave in parallel.
module fft_bitrev_frame_buffer #(
  parameter  int SAMPLES = 8,
  parameter  int WIDTH   = 3,
  localparam int ADDR    = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] frame_data [SAMPLES],
  output logic [ADDR-1:0]  fill_level
);

  logic [WIDTH-1:0] bank_mem [2][SAMPLES];
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [ADDR-1:0]  wr_idx;
  logic             accept;
  logic             consume;
  logic             last_in;

  function automatic logic [ADDR-1:0] bitrev(input logic [ADDR-1:0] k);
    logic [ADDR-1:0] r;
    r = '0;
    for (int b = 0; b < ADDR; b++) r[b] = k[ADDR-1-b];
    return r;
  endfunction

  // clear outranks both handshakes, so neither may fire in a clear cycle
  assign in_ready    = !full[wr_bank];
  assign frame_valid = full[rd_bank];
  assign accept      = in_valid && in_ready && !clear;
  assign consume     = frame_valid && frame_ready && !clear;
  assign last_in     = (wr_idx == ADDR'(SAMPLES - 1));
  assign fill_level  = wr_idx;

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) frame_data[i] = bank_mem[rd_bank][i];
  end

  // Bank control: accept and consume always address different banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (clear) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      if (accept) begin
        if (last_in) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Sample storage; a full bank is never written since in_ready is low for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < SAMPLES; i++) bank_mem[b][i] <= '0;
    end else if (accept) begin
      bank_mem[wr_bank][bitrev(wr_idx)] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_frame_buffer.sv
// Randomized bench for fft_bitrev_frame_buffer against a frame-queue reference model.
module tb_fft_bitrev_frame_buffer;
  localparam int SAMPLES = 8;
  localparam int WIDTH   = 3;
  localparam int ADDR    = $clog2(SAMPLES);
  localparam int SW      = SAMPLES * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             frame_valid;
  logic             frame_ready = 1'b0;
  logic [WIDTH-1:0] frame_data [SAMPLES];
  logic [ADDR-1:0]  fill_level;

  fft_bitrev_frame_buffer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] tbl_fwd [SAMPLES] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic [WIDTH-1:0] tbl_rev [SAMPLES] = '{3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};

  logic [SW-1:0] got_flat;
  always_comb begin
    got_flat = '0;
    for (int i = 0; i < SAMPLES; i++) got_flat[i*WIDTH +: WIDTH] = frame_data[i];
  end

  // Reference model: queue of completed frames in arrival order plus the partial frame
  logic [SW-1:0]    fq [$];
  logic [SW-1:0]    part;
  int               part_n;
  logic             exp_in_ready;
  logic             exp_fv;
  logic [ADDR-1:0]  exp_fill;
  logic [SW-1:0]    exp_flat;

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < ADDR; b++) r |= ((k >> b) & 1) << (ADDR - 1 - b);
    return r;
  endfunction

  task automatic model_expect();
    exp_in_ready = (fq.size() < 2);
    exp_fv       = (fq.size() > 0);
    exp_fill     = part_n[ADDR-1:0];
    exp_flat     = '0;
    if (fq.size() > 0)
      for (int k = 0; k < SAMPLES; k++)
        exp_flat[brev(k)*WIDTH +: WIDTH] = fq[0][k*WIDTH +: WIDTH];
  endtask

  task automatic model_reset();
    fq.delete();
    part   = '0;
    part_n = 0;
    model_expect();
  endtask

  task automatic model_edge();
    logic do_acc, do_cons;
    if (clear) begin
      fq.delete();
      part_n = 0;
    end else begin
      do_acc  = in_valid && (fq.size() < 2);
      do_cons = frame_ready && (fq.size() > 0);
      if (do_cons) void'(fq.pop_front());
      if (do_acc) begin
        part[part_n*WIDTH +: WIDTH] = in_data;
        part_n++;
        if (part_n == SAMPLES) begin
          fq.push_back(part);
          part_n = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    model_expect();
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    logic took;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 40; t++) begin
      took = in_ready;
      cycle();
      if (took) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_timeout in_ready=%0b never accepted sample %0d", in_ready, d);
  endtask

  task automatic do_reset();
    clear = 1'b0; in_valid = 1'b0; frame_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, frame_valid, fill_level} !== {1'b1, 1'b0, {ADDR{1'b0}}}) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/fv/fill %0b/%0b/%0d required 1/0/0", in_ready, frame_valid, fill_level);
    end
    checks++;
    if (got_flat !== '0) begin
      errors++; $display("FAIL reset_data got %h required 0", got_flat);
    end
    #2 rst_n = 1'b1;
    cycle();
    checks++;
    if ({in_ready, frame_valid, fill_level} !== {exp_in_ready, exp_fv, exp_fill}) begin
      errors++;
      $display("FAIL post_reset got rdy/fv/fill %0b/%0b/%0d required %0b/%0b/%0d",
               in_ready, frame_valid, fill_level, exp_in_ready, exp_fv, exp_fill);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int k = 0; k < SAMPLES - 1; k++) send(WIDTH'(k));
    checks++;
    if ({frame_valid, fill_level} !== {1'b0, 3'd7}) begin
      errors++; $display("FAIL single_partial got fv/fill %0b/%0d required 0/7", frame_valid, fill_level);
    end
    send(WIDTH'(SAMPLES - 1));
    checks++;
    if ({in_ready, frame_valid, fill_level} !== {1'b1, 1'b1, {ADDR{1'b0}}}) begin
      errors++;
      $display("FAIL single_done got rdy/fv/fill %0b/%0b/%0d required 1/1/0", in_ready, frame_valid, fill_level);
    end
    for (int i = 0; i < SAMPLES; i++) begin
      checks++;
      if (frame_data[i] !== tbl_fwd[i]) begin
        errors++; $display("FAIL single_data[%0d] got %0d required %0d", i, frame_data[i], tbl_fwd[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] d17;
    do_reset();
    for (int k = 0; k < SAMPLES; k++) send(WIDTH'(k));
    for (int k = 0; k < SAMPLES; k++) send(WIDTH'(SAMPLES - 1 - k));
    d17 = WIDTH'($urandom);
    in_valid = 1'b1; in_data = d17;
    cycle(); cycle();
    checks++;
    if ({in_ready, frame_valid, fill_level} !== {1'b0, 1'b1, {ADDR{1'b0}}}) begin
      errors++;
      $display("FAIL bp_stall got rdy/fv/fill %0b/%0b/%0d required 0/1/0", in_ready, frame_valid, fill_level);
    end
    checks++;
    if (got_flat !== exp_flat) begin
      errors++; $display("FAIL bp_hold got %h required %h", got_flat, exp_flat);
    end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    checks++;
    if ({in_ready, frame_valid} !== 2'b11) begin
      errors++; $display("FAIL bp_release got rdy/fv %0b/%0b required 1/1", in_ready, frame_valid);
    end
    for (int i = 0; i < SAMPLES; i++) begin
      checks++;
      if (frame_data[i] !== tbl_rev[i]) begin
        errors++; $display("FAIL bp_frame2[%0d] got %0d required %0d", i, frame_data[i], tbl_rev[i]);
      end
    end
    cycle();
    in_valid = 1'b0;
    checks++;
    if (fill_level !== 3'd1 || fill_level !== exp_fill) begin
      errors++; $display("FAIL bp_17th got fill %0d required 1", fill_level);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 2*SAMPLES - 1; k++) send(WIDTH'($urandom));
    in_valid = 1'b1; in_data = WIDTH'($urandom); frame_ready = 1'b1;
    cycle();
    in_valid = 1'b0; frame_ready = 1'b0;
    checks++;
    if ({in_ready, frame_valid, fill_level} !== {1'b1, 1'b1, {ADDR{1'b0}}}) begin
      errors++;
      $display("FAIL simul_ctrl got rdy/fv/fill %0b/%0b/%0d required 1/1/0", in_ready, frame_valid, fill_level);
    end
    checks++;
    if (got_flat !== exp_flat) begin
      errors++; $display("FAIL simul_frame2 got %h required %h", got_flat, exp_flat);
    end
    frame_ready = 1'b1;
    cycle();
    frame_ready = 1'b0;
    checks++;
    if ({in_ready, frame_valid} !== 2'b10) begin
      errors++; $display("FAIL simul_drain got rdy/fv %0b/%0b required 1/0", in_ready, frame_valid);
    end
  endtask

  task automatic test_gapped_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(WIDTH'($urandom));
      repeat ($urandom_range(1, 3)) cycle();
    end
    checks++;
    if (fill_level !== 3'd5) begin
      errors++; $display("FAIL gap_fill got %0d required 5", fill_level);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({in_ready, frame_valid, fill_level} !== {1'b1, 1'b0, {ADDR{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset got rdy/fv/fill %0b/%0b/%0d required 1/0/0", in_ready, frame_valid, fill_level);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < SAMPLES; k++) send(WIDTH'(k));
    for (int i = 0; i < SAMPLES; i++) begin
      checks++;
      if (frame_data[i] !== tbl_fwd[i] || frame_valid !== 1'b1) begin
        errors++;
        $display("FAIL gap_frame[%0d] got %0d fv %0b required %0d fv 1", i, frame_data[i], frame_valid, tbl_fwd[i]);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int k = 0; k < SAMPLES + 3; k++) send(WIDTH'($urandom));
    checks++;
    if ({frame_valid, fill_level} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL clear_pre got fv/fill %0b/%0d required 1/3", frame_valid, fill_level);
    end
    clear = 1'b1; frame_ready = 1'b1; in_valid = 1'b1; in_data = WIDTH'($urandom);
    cycle();
    clear = 1'b0; frame_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if ({in_ready, frame_valid, fill_level} !== {1'b1, 1'b0, {ADDR{1'b0}}}) begin
      errors++;
      $display("FAIL clear_post got rdy/fv/fill %0b/%0b/%0d required 1/0/0", in_ready, frame_valid, fill_level);
    end
    for (int k = 0; k < SAMPLES; k++) send(WIDTH'($urandom));
    checks++;
    if (frame_valid !== exp_fv || got_flat !== exp_flat) begin
      errors++;
      $display("FAIL clear_refill got fv %0b data %h required fv %0b data %h", frame_valid, got_flat, exp_fv, exp_flat);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = WIDTH'($urandom);
      frame_ready = ($urandom_range(0, 2) == 0);
      clear       = ($urandom_range(0, 149) == 0);
      cycle();
      checks++;
      if ({in_ready, frame_valid, fill_level} !== {exp_in_ready, exp_fv, exp_fill}) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d got rdy/fv/fill %0b/%0b/%0d required %0b/%0b/%0d",
                 n, in_ready, frame_valid, fill_level, exp_in_ready, exp_fv, exp_fill);
      end
      if (exp_fv) begin
        checks++;
        if (got_flat !== exp_flat) begin
          errors++; $display("FAIL rand_data cyc %0d got %h required %h", n, got_flat, exp_flat);
        end
      end
    end
    in_valid = 1'b0; frame_ready = 1'b0; clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_simultaneous();
    test_gapped_reset();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
